// File: rtl/memory_banked_lsu_pkg.sv
// Shared types and helpers for the byte-lane-interleaved load/store unit.
// Access sizes are log2 of the byte count; the state enum drives the zero-fill sequencer.
package mem_lsu_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} access_size_t;

  typedef enum logic {ST_CLEAR, ST_READY} lsu_state_t;

  // Lanes below the start lane hold the bytes that spilled into the next row.
  function automatic logic lane_row_offset(input int lane, input int s);
    return lane < s;
  endfunction

endpackage

// File: rtl/memory_banked_lsu_ram.sv
// Single-port on-chip RAM bank with registered read (read-before-write on the same row).
// One instance per byte lane.
module ramOnChip #(
  parameter int ramSize = 16384,
  parameter int ramWide = 8
) (
  input  logic                       clk,
  input  logic                       wren,
  input  logic [$clog2(ramSize)-1:0] addr,
  input  logic [ramWide-1:0]         wdata,
  output logic [ramWide-1:0]         rdata
);

  logic [ramWide-1:0] mem [ramSize];

  always_ff @(posedge clk) begin
    if (wren) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_banked_lsu.sv
// Byte-lane-interleaved data memory: any-alignment byte/half/word accesses over NUM_LANES banks,
// two-cycle response pipe shared by loads and stores, and a post-reset zero-fill sequencer.
module memory_banked_lsu
  import mem_lsu_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int LANE_W     = 8,
  parameter int ROWS       = 16384,
  parameter int ADDR_W     = 32,
  parameter int INIT_CLEAR = 1
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [1:0]                  req_size,
  input  logic                        req_unsigned,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [NUM_LANES*LANE_W-1:0] req_wdata,
  output logic                        rsp_valid,
  output logic [NUM_LANES*LANE_W-1:0] rsp_rdata,
  output logic                        rsp_err,
  output logic                        init_done
);

  localparam int LANE_BITS = $clog2(NUM_LANES);
  localparam int ROW_W     = $clog2(ROWS);
  localparam int DATA_W    = NUM_LANES * LANE_W;
  localparam logic [ADDR_W:0] TOTAL_BYTES = (ADDR_W+1)'(NUM_LANES * ROWS);
  localparam lsu_state_t RESET_STATE = lsu_state_t'((INIT_CLEAR != 0) ? ST_CLEAR : ST_READY);

  lsu_state_t       stateReg, stateNext;
  logic [ROW_W-1:0] clearRowReg, clearRowNext;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stateReg    <= RESET_STATE;
      clearRowReg <= '0;
    end else begin
      stateReg    <= stateNext;
      clearRowReg <= clearRowNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    clearRowNext = clearRowReg;
    req_ready    = 1'b0;
    case (stateReg)
      ST_CLEAR: begin
        clearRowNext = clearRowReg + ROW_W'(1);
        if (clearRowReg == ROW_W'(ROWS - 1)) begin
          stateNext    = ST_READY;
          clearRowNext = '0;
        end
      end
      ST_READY: req_ready = 1'b1;
      default:  stateNext = ST_CLEAR;
    endcase
  end

  // Request decode (stage 0)
  logic [LANE_BITS-1:0] reqShift;
  logic [ROW_W-1:0]     reqRow;
  logic [ADDR_W:0]      reqLast;
  logic [DATA_W-1:0]    wdataRot;
  logic                 reqErr, accept, storeEn, isClear;
  int                   nbInt;

  always_comb begin
    reqShift = req_addr[LANE_BITS-1:0];
    reqRow   = req_addr[LANE_BITS +: ROW_W];
    nbInt    = 1 << req_size;
    // One extra bit so a request straddling the top of the address space cannot wrap to 0.
    reqLast  = {1'b0, req_addr} + (ADDR_W+1)'(nbInt - 1);
    reqErr   = (int'(req_size) > LANE_BITS) || (reqLast >= TOTAL_BYTES);
    accept   = req_valid && req_ready;
    storeEn  = accept && req_we && !reqErr;
    isClear  = (stateReg == ST_CLEAR);
    wdataRot = DATA_W'(({req_wdata, req_wdata} << (int'(reqShift) * LANE_W)) >> DATA_W);
  end

  logic [DATA_W-1:0] bankRdata;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : gLane
      logic [LANE_BITS-1:0] laneByte;
      logic                 laneWren;
      logic [ROW_W-1:0]     laneAddr;
      logic [LANE_W-1:0]    laneWdata;

      assign laneByte  = LANE_BITS'(gi) - reqShift;
      assign laneWren  = isClear || (storeEn && (int'(laneByte) < nbInt));
      assign laneAddr  = isClear ? clearRowReg
                                 : reqRow + ROW_W'(lane_row_offset(gi, int'(reqShift)));
      assign laneWdata = isClear ? '0 : wdataRot[gi*LANE_W +: LANE_W];

      ramOnChip #(
        .ramSize(ROWS),
        .ramWide(LANE_W)
      ) uBank (
        .clk  (Clk),
        .wren (laneWren),
        .addr (laneAddr),
        .wdata(laneWdata),
        .rdata(bankRdata[gi*LANE_W +: LANE_W])
      );
    end
  endgenerate

  logic                 p1ValidReg, p1WeReg, p1ErrReg, p1UnsignedReg;
  logic [1:0]           p1SizeReg;
  logic [LANE_BITS-1:0] p1ShiftReg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      p1ValidReg    <= 1'b0;
      p1WeReg       <= 1'b0;
      p1ErrReg      <= 1'b0;
      p1UnsignedReg <= 1'b0;
      p1SizeReg     <= '0;
      p1ShiftReg    <= '0;
    end else begin
      p1ValidReg    <= accept;
      p1WeReg       <= req_we;
      p1ErrReg      <= reqErr;
      p1UnsignedReg <= req_unsigned;
      p1SizeReg     <= req_size;
      p1ShiftReg    <= reqShift;
    end
  end

  // Stage 1: rotate lanes back into byte order, mask to size and extend
  logic [DATA_W-1:0] loadData;
  logic              signBit;
  int                p1Nb;

  always_comb begin
    loadData = DATA_W'({bankRdata, bankRdata} >> (int'(p1ShiftReg) * LANE_W));
    p1Nb     = 1 << p1SizeReg;
    signBit  = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (k == p1Nb - 1) begin
        signBit = loadData[k*LANE_W + LANE_W - 1];
      end
    end
    for (int k = 0; k < NUM_LANES; k++) begin
      if (k >= p1Nb) begin
        loadData[k*LANE_W +: LANE_W] = {LANE_W{signBit && !p1UnsignedReg}};
      end
    end
    if (!p1ValidReg || p1WeReg || p1ErrReg) begin
      loadData = '0;
    end
  end

  logic              rspValidReg, rspErrReg, initDoneReg;
  logic [DATA_W-1:0] rspDataReg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rspValidReg <= 1'b0;
      rspErrReg   <= 1'b0;
      rspDataReg  <= '0;
      initDoneReg <= 1'b0;
    end else begin
      rspValidReg <= p1ValidReg;
      rspErrReg   <= p1ValidReg && p1ErrReg;
      rspDataReg  <= loadData;
      initDoneReg <= (stateReg == ST_READY);
    end
  end

  assign rsp_valid = rspValidReg;
  assign rsp_err   = rspErrReg;
  assign rsp_rdata = rspDataReg;
  assign init_done = initDoneReg;

endmodule

// File: tb/tb_memory_banked_lsu.sv
// Self-checking bench for memory_banked_lsu: directed vector table, randomized traffic against a
// byte-array reference model, and reset/zero-fill corner sequences.
module tb_memory_banked_lsu;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  memory_banked_lsu dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .init_done   (init_done)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  localparam int MEM_BYTES = 65536;
  logic [7:0] model [MEM_BYTES];

  typedef struct {
    logic [31:0] data;
    bit          err;
    int          acc;
  } exp_t;
  exp_t expQ[$];

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    bit          expErr;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit modelErr(input logic [1:0] size, input logic [31:0] addr);
    longint last;
    last = longint'(addr) + longint'(1 << size) - 1;
    return (size > 2'd2) || (last >= MEM_BYTES);
  endfunction

  function automatic logic [31:0] modelLoad(input logic [1:0] size, input bit uns,
                                            input logic [31:0] addr);
    int          nb;
    logic [31:0] v;
    nb = 1 << size;
    v  = 32'd0;
    for (int k = 0; k < nb; k++) v |= 32'(model[int'(addr) + k]) << (8 * k);
    if (!uns && nb < 4 && v[8*nb-1]) v |= ~((32'd1 << (8 * nb)) - 32'd1);
    return v;
  endfunction

  task automatic modelClear();
    for (int i = 0; i < MEM_BYTES; i++) model[i] = 8'h00;
  endtask

  // Drive one request at a negedge; it is accepted at the following posedge.
  task automatic issue(input vec_t v, input bit useExp);
    exp_t e;
    bit   err;
    err = modelErr(v.size, v.addr);
    e.acc = cyc;
    if (useExp) begin
      e.data = v.expData;
      e.err  = v.expErr;
    end else begin
      e.err  = err;
      e.data = (err || v.we) ? 32'd0 : modelLoad(v.size, v.uns, v.addr);
    end
    if (v.we && !err) begin
      for (int k = 0; k < (1 << v.size); k++) model[int'(v.addr) + k] = v.wdata[8*k +: 8];
    end
    expQ.push_back(e);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(negedge Clk);
    req_valid = 1'b0;
  endtask

  // Response monitor: order, data, error flag and the fixed two-cycle latency.
  always @(negedge Clk) begin
    if (Reset_n && rsp_valid) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp actual rdata=%h err=%0d required=no response", rsp_rdata, rsp_err);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if (rsp_rdata !== e.data || rsp_err !== e.err || cyc != e.acc + 2) begin
          errors++;
          $display("FAIL rsp acc=%0d actual rdata=%h err=%0d cyc=%0d required rdata=%h err=%0d cyc=%0d",
                   e.acc, rsp_rdata, rsp_err, cyc, e.data, e.err, e.acc + 2);
        end else begin
          $display("rsp acc=%0d rdata=%h err=%0d ok", e.acc, rsp_rdata, rsp_err);
        end
      end
    end
  end

  vec_t tbl[16];
  int   lowCnt;

  initial begin
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,    32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,    32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h21,    32'h00000080, 32'h00000000, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h21,    32'h0,        32'hFFFFFF80, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h21,    32'h0,        32'h00000080, 1'b0};
    tbl[5]  = '{1'b0, 2'd1, 1'b0, 32'h20,    32'h0,        32'hFFFF8000, 1'b0};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 32'h3,     32'h11223344, 32'h00000000, 1'b0};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h3,     32'h0,        32'h11223344, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 1'b1, 32'h4,     32'h0,        32'h00000033, 1'b0};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'hFFFE,  32'h0,        32'h00000000, 1'b1};
    tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h10000, 32'hCAFEF00D, 32'h00000000, 1'b1};
    tbl[11] = '{1'b0, 2'd2, 1'b0, 32'hFFFC,  32'h0,        32'h00000000, 1'b0};
    tbl[12] = '{1'b0, 2'd3, 1'b0, 32'h0,     32'h0,        32'h00000000, 1'b1};
    tbl[13] = '{1'b0, 2'd1, 1'b1, 32'h11,    32'h0,        32'h0000ADBE, 1'b0};
    tbl[14] = '{1'b1, 2'd1, 1'b0, 32'hFFFF,  32'h00001234, 32'h00000000, 1'b1};
    tbl[15] = '{1'b0, 2'd0, 1'b1, 32'hFFFF,  32'h0,        32'h00000000, 1'b0};

    modelClear();
    repeat (3) @(negedge Clk);
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_init_done", init_done, 0);

    // Zero-fill with a load held pending the whole time.
    Reset_n = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h100;
    lowCnt = 0;
    for (int i = 0; i < MEM_BYTES / 4; i++) begin
      if (!req_ready) lowCnt++;
      @(negedge Clk);
    end
    check("clear_ready_low_cycles", lowCnt, MEM_BYTES / 4);
    check("ready_after_clear", req_ready, 1);
    check("init_done_lags_ready", init_done, 0);
    expQ.push_back('{32'h0, 1'b0, cyc});
    @(negedge Clk);
    req_valid = 1'b0;
    check("init_done_set", init_done, 1);

    foreach (tbl[i]) issue(tbl[i], 1'b1);

    for (int n = 0; n < 400; n++) begin
      vec_t v;
      v.we    = $urandom_range(0, 1);
      v.uns   = $urandom_range(0, 1);
      v.size  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      v.wdata = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: v.addr = $urandom_range(0, 127);
        6, 7:             v.addr = 32'hFFF0 + $urandom_range(0, 15);
        8:                v.addr = $urandom_range(0, MEM_BYTES - 1);
        default:          v.addr = 32'hFFFE + $urandom_range(0, 4);
      endcase
      v.expData = 32'h0;
      v.expErr  = 1'b0;
      issue(v, 1'b0);
      if ($urandom_range(0, 3) == 0) @(negedge Clk);
    end
    repeat (4) @(negedge Clk);
    check("queue_empty_before_reset", expQ.size(), 0);

    // Reset with two loads in flight: both responses must be dropped.
    begin
      vec_t v;
      v = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0};
      issue(v, 1'b0);
      issue(v, 1'b0);
    end
    Reset_n = 1'b0;
    expQ.delete();
    modelClear();
    @(negedge Clk);
    check("inflight_reset_rsp_valid", rsp_valid, 0);
    @(negedge Clk);
    check("inflight_reset_rsp_valid2", rsp_valid, 0);

    // Release, then reset again in the middle of the zero-fill.
    Reset_n = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    repeat (100) @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    check("midclear_reset_ready", req_ready, 0);
    check("midclear_reset_init_done", init_done, 0);
    Reset_n = 1'b1;
    lowCnt = 0;
    for (int i = 0; i < MEM_BYTES / 4; i++) begin
      if (!req_ready) lowCnt++;
      @(negedge Clk);
    end
    check("reclear_ready_low_cycles", lowCnt, MEM_BYTES / 4);
    check("ready_after_reclear", req_ready, 1);
    expQ.push_back('{32'h0, 1'b0, cyc});
    @(negedge Clk);
    req_valid = 1'b0;

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge Clk);
    check("final_queue_drained", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
